// File: rtl/traffic_light.sv
// Single-approach traffic light: RED/GREEN/YELLOW Moore FSM with a per-state cycle timer.
// Define TRAFFIC_LIGHT_EXTEND_EN to let a waiting vehicle stretch GREEN up to MAX_GREEN cycles.
module traffic_light #(
  parameter int GREEN_TIME  = 4,
  parameter int YELLOW_TIME = 2,
  parameter int RED_TIME    = 3,
  parameter int MAX_GREEN   = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s,
  output logic [1:0] light
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
`ifdef TRAFFIC_LIGHT_EXTEND_EN
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
`endif

  // Elaboration-time sanity on the timing parameters.
  generate
    if (GREEN_TIME < 1 || YELLOW_TIME < 1 || RED_TIME < 1 || MAX_GREEN < GREEN_TIME ||
        (2 ** CNT_W) <= MAX_GREEN || (2 ** CNT_W) <= RED_TIME ||
        (2 ** CNT_W) <= YELLOW_TIME)
      $error("traffic_light: illegal timing parameters");
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] timer;

  // light always mirrors the state being entered, so it is a registered Moore output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RED;
      timer <= '0;
      light <= RED;
    end else begin
      unique case (state)
        RED: begin
          if (timer == RED_LAST && s) begin
            state <= GREEN;
            timer <= '0;
            light <= GREEN;
          end else if (timer != RED_LAST) begin
            timer <= timer + 1'b1;
          end
        end
        GREEN: begin
`ifdef TRAFFIC_LIGHT_EXTEND_EN
          if ((!s && timer >= GRN_LAST) || timer == MAX_LAST) begin
`else
          if (timer == GRN_LAST) begin
`endif
            state <= YELLOW;
            timer <= '0;
            light <= YELLOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        YELLOW: begin
          if (timer == YEL_LAST) begin
            state <= RED;
            timer <= '0;
            light <= RED;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= RED;
          timer <= '0;
          light <= RED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: reset behaviour, idle red, steady cycle, early s drop,
// mid-yellow abort and (with TRAFFIC_LIGHT_EXTEND_EN) green extension.
module tb_traffic_light;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s   = 1'b0;
  logic [1:0] light;

  int checks = 0;
  int errors = 0;

`ifdef TRAFFIC_LIGHT_EXTEND_EN
  localparam int GLEN = 8;
`else
  localparam int GLEN = 4;
`endif
  localparam int PER = 3 + GLEN + 2;

  traffic_light dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s),
    .light(light)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected lamp in cycle i after reset release with s held 1.
  function automatic logic [1:0] cyc_exp(input int i);
    int p;
    p = i % PER;
    if (p < 3)         return 2'b00;
    else if (p < 3 + GLEN) return 2'b01;
    else               return 2'b10;
  endfunction

  initial begin
    // async reset before any clock edge
    #1 rst = 1'b1;
    #1 chk("rst_async_pre_clk", light, 2'b00);
    for (int i = 0; i < 10; i++) begin
      s = i[0];
      step;
      chk("rst_hold", light, 2'b00);
    end

    // idle red with no request, then immediate grant
    s   = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("red_idle", light, 2'b00);
    end
    s = 1'b1;
    #1 chk("s_unsampled", light, 2'b00);
    step;
    chk("grant_after_idle", light, 2'b01);
    for (int i = 1; i < GLEN; i++) begin
      step;
      chk("grant_green_len", light, 2'b01);
    end
    step;
    chk("grant_to_yellow", light, 2'b10);

    // steady cycle with s held 1
    rst = 1'b1;
    #1 chk("rst_async_mid", light, 2'b00);
    step;
    rst = 1'b0;
    s   = 1'b1;
    chk("steady_c0", light, cyc_exp(0));
    for (int i = 1; i <= 2 * PER; i++) begin
      step;
      chk("steady", light, cyc_exp(i));
    end

    // s drops in the 2nd green cycle: green still full length, then red holds
    rst = 1'b1;
    step;
    rst = 1'b0;
    s   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step;
      chk("drop_pre", light, cyc_exp(i));
    end
    s = 1'b0;
    for (int i = 5; i <= 14; i++) begin
      step;
      chk("drop_seq", light, (i <= 6) ? 2'b01 : (i <= 8) ? 2'b10 : 2'b00);
    end

    // abort in 2nd yellow cycle, then full minimum red
    rst = 1'b1;
    step;
    rst = 1'b0;
    s   = 1'b1;
    for (int i = 1; i <= 3 + GLEN + 1; i++) begin
      step;
      chk("to_yellow2", light, cyc_exp(i));
    end
    #2 rst = 1'b1;
    #1 chk("rst_mid_yellow", light, 2'b00);
    step;
    chk("rst_mid_yellow_hold", light, 2'b00);
    rst = 1'b0;
    chk("post_abort_r0", light, 2'b00);
    for (int i = 1; i <= 2; i++) begin
      step;
      chk("post_abort_red", light, 2'b00);
    end
    step;
    chk("post_abort_green", light, 2'b01);

`ifdef TRAFFIC_LIGHT_EXTEND_EN
    // extension: s drops during 6th green cycle -> 6 greens then yellow
    rst = 1'b1;
    step;
    rst = 1'b0;
    s   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step;
      chk("ext_pre", light, cyc_exp(i));
    end
    s = 1'b0;
    for (int i = 9; i <= 13; i++) begin
      step;
      chk("ext_drop", light, (i <= 10) ? 2'b10 : 2'b00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
Single-approach traffic light controller. A 3-state Moore FSM (RED, GREEN, YELLOW) with a per-state cycle timer. It grants GREEN only when the vehicle sensor `s` requests service and the minimum red time has elapsed. It sits at the intersection-control level, and its 2-bit `light` code drives the lamp decoder.

Parameters:
- GREEN_TIME, 4: cycles GREEN is held (fixed length, or minimum length when extension is enabled); must be >=1.
- YELLOW_TIME, 2: cycles YELLOW is held; must be >=1.
- RED_TIME, 3: minimum cycles RED is held before GREEN may be granted; must be >=1.
- MAX_GREEN, 8: upper bound on GREEN cycles, used only with TRAFFIC_LIGHT_EXTEND_EN; must be >=GREEN_TIME.
- CNT_W, 8: timer width; must hold max(GREEN_TIME, YELLOW_TIME, RED_TIME, MAX_GREEN).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- s, input, 1: vehicle sensor/request, sampled on the rising edge of clk; 1 = vehicle waiting.
- light, output, 2: lamp code. 2'b00 = RED, 2'b01 = GREEN, 2'b10 = YELLOW; 2'b11 is never driven.

Behaviour:
- Reset:
  - rst=1 immediately forces state RED, light=2'b00 and timer=0, regardless of clk.
  - The block stays in this condition while rst=1.
  - Asserting rst mid-GREEN or mid-YELLOW aborts to RED at once.
- Output: light is a registered Moore output, a pure function of state. No combinational path from s to light.
- Timer:
  - Cleared to 0 on every state transition.
  - Increments by 1 each cycle the state is unchanged.
  - In RED it saturates at RED_TIME-1. It never wraps.
- RED:
  - Transition to GREEN on the edge where timer==RED_TIME-1 and s==1.
  - If s==0, stay RED indefinitely with the timer saturated. A later s=1 grants GREEN on the next edge.
  - s=1 earlier than that does nothing.
  - After reset release with s held 1, RED lasts exactly RED_TIME cycles.
- GREEN: at timer==GREEN_TIME-1, go to YELLOW. s is ignored in this state (without the extension). GREEN lasts exactly GREEN_TIME cycles.
- YELLOW: at timer==YELLOW_TIME-1, go to RED. s is ignored. YELLOW lasts exactly YELLOW_TIME cycles.
- RED after YELLOW: re-entered with timer=0, so the minimum red time is always enforced between greens.
- Steady state: with s held 1 and defaults, the period is 9 cycles (RED 3, GREEN 4, YELLOW 2).
- Illegal state encoding: recovers to RED with timer=0 on the next clock edge.
- s changing within a cycle: has no effect until it is sampled at the rising edge.

Optional Feature:
Macro TRAFFIC_LIGHT_EXTEND_EN (green extension).
- Defined:
  - At timer==GREEN_TIME-1 with s==1, stay GREEN and keep counting.
  - Leave GREEN for YELLOW on the first edge where s==0 and timer>=GREEN_TIME-1, or where timer==MAX_GREEN-1, whichever comes first.
  - GREEN length is therefore in [GREEN_TIME, MAX_GREEN].
- Not defined: GREEN is exactly GREEN_TIME cycles, MAX_GREEN is unused, and no extension logic is synthesized.

Test Plan:
1. Hold rst=1 for 10 cycles while toggling s -> light=2'b00 throughout. Assert rst asynchronously between edges -> light=2'b00 before the next edge.
2. Release rst with s=0 for 20 cycles -> light stays 2'b00. Then set s=1 -> GREEN (2'b01) is reached one edge after s=1 is sampled, since the minimum red time has already elapsed.
3. Release rst with s=1 constant, defaults -> 3 cycles 00, 4 cycles 01, 2 cycles 10, then repeat with a 9-cycle period.
4. Drop s to 0 during GREEN -> GREEN still lasts 4 cycles, then YELLOW 2 cycles, then RED held while s=0.
5. Assert rst in the 2nd YELLOW cycle -> light=00 immediately. After release with s=1 -> RED lasts a full 3 cycles before GREEN.
6. With TRAFFIC_LIGHT_EXTEND_EN and s=1 constant -> GREEN lasts 8 cycles (MAX_GREEN). With s dropped after 5 GREEN cycles -> GREEN ends after the 6th cycle (first sample of s=0), then YELLOW.
